imem_responder: RTL and testbench

- Instruction-memory responder for the RV32I datapath. It serves fetch requests issued from the program-counter address over a valid/ready request channel.
- Each instruction word is returned on a valid/ready response channel after a configurable number of wait states.
- Provides misalignment and out-of-range error signalling.
- Includes a side write port so the bench or boot logic can preload program words.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/imem_array.sv | 36 +++
 rtl/imem_responder.sv | 126 ++++++++++++
 tb/tb_imem_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions.
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), returned on fetch errors
//   XLEN          : datapath width
//   imem_state_t  : instruction-memory responder FSM states
//   word_in_range : true when a byte address selects a word below depth
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_t;

  function automatic logic word_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: DEPTH_WORDS x 32 synchronous RAM.
//   clk, reset : clock; reset clears only the read data register
//   wr_en/wr_idx/wr_data : write port, word index, caller guarantees range
//   rd_en/rd_idx/rd_data : registered read port, caller guarantees range
// Read and write on the same edge to the same word return the old data.
module imem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the RV32I fetch path.
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_addr : fetch request channel (byte PC address)
//   rsp_valid/rsp_ready/rsp_instr/rsp_err : response channel
//   wr_en/wr_addr/wr_data : preload port, active in every state
// Responses appear WAIT_CYCLES+1 edges after the accept edge (accept edge
// counted). Misaligned or out-of-range fetches return NOP with rsp_err set.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic            rsp_err,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        err_q;

  logic        accept;
  logic        enter_resp;
  logic [31:0] lookup_addr;
  logic        lookup_bad;
  logic        rd_en;
  logic        wr_ok;
  logic [31:0] rd_data;
  logic        unused_wr_lsb;

  assign req_ready = (state_q == IMEM_IDLE) && reset;
  assign rsp_valid = (state_q == IMEM_RESP);
  assign rsp_err   = err_q;
  // The RAM read register only loads on good fetches, so an error response
  // is formed by substituting NOP here rather than writing it into the RAM path.
  assign rsp_instr = err_q ? NOP_INSTR : rd_data;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IMEM_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = IMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = IMEM_WAIT;
          end
        end
      end
      IMEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = IMEM_RESP;
          enter_resp = 1'b1;
        end
      end
      IMEM_RESP: begin
        if (rsp_ready) begin
          state_d = IMEM_IDLE;
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // With zero wait states the RAM is read on the accept edge itself, before
  // the address register has been loaded, so the live request address is used.
  assign lookup_addr = (state_q == IMEM_IDLE) ? req_addr : addr_q;
  assign lookup_bad  = (lookup_addr[1:0] != 2'b00) ||
                       !word_in_range(lookup_addr, DEPTH_WORDS);
  assign rd_en       = enter_resp && !lookup_bad;
  assign wr_ok       = wr_en && word_in_range(wr_addr, DEPTH_WORDS);
  assign unused_wr_lsb = ^wr_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        cnt_q  <= WAIT_INIT;
      end else if (state_q == IMEM_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        err_q <= lookup_bad;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_idx  (wr_addr[AW+1:2]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_idx  (lookup_addr[AW+1:2]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int unsigned MAIN_WAIT = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  // main instance: WAIT_CYCLES=2
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
  logic [31:0] req_addr, rsp_instr, wr_addr, wr_data;
  // second instance: WAIT_CYCLES=0
  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_wr_en;
  logic [31:0] z_req_addr, z_rsp_instr, z_wr_addr, z_wr_data;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(MAIN_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_err(rsp_err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_instr(z_rsp_instr),
    .rsp_err(z_rsp_err), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic z_write_word(input logic [31:0] a, input logic [31:0] d);
    z_wr_en = 1'b1; z_wr_addr = a; z_wr_data = d;
    tick();
    z_wr_en = 1'b0;
  endtask

  // Issue one request on the main instance; returns with the DUT in RESP.
  task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    exp_t e;
    int edges;
    e.instr = ei; e.err = ee;
    sb.push_back(e);
    req_valid = 1'b1; req_addr = a;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_req_ready: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != MAIN_WAIT + 1) begin
      errors++; $display("FAIL latency addr=%h: got %0d edges expected %0d", a, edges, MAIN_WAIT + 1);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty addr=%h", a);
    end else begin
      e = sb.pop_front();
      if (rsp_instr !== e.instr || rsp_err !== e.err) begin
        errors++;
        $display("FAIL response addr=%h: got instr=%h err=%b expected instr=%h err=%b",
                 a, rsp_instr, rsp_err, e.instr, e.err);
      end
    end
  endtask

  task automatic complete;
    logic [31:0] held;
    held = rsp_instr;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_instr !== held) begin
      errors++;
      $display("FAIL complete: got valid=%b ready=%b instr=%h expected valid=0 ready=1 instr=%h",
               rsp_valid, req_ready, rsp_instr, held);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b instr=%h err=%b ready=%b expected 0/0/0/0",
               rsp_valid, rsp_instr, rsp_err, req_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b z_ready=%b z_valid=%b expected 1/1/0",
               req_ready, z_req_ready, z_rsp_valid);
    end
  endtask

  task automatic test_fetch;
    write_word(32'h0, 32'h0050_0093);
    write_word(32'h4, 32'h00A0_0113);
    issue(32'h0, 32'h0050_0093, 1'b0);
    complete();
    issue(32'h4, 32'h00A0_0113, 1'b0);
    complete();
  endtask

  task automatic test_errors;
    issue(32'h6, NOP, 1'b1);
    complete();
    issue(32'h1000, NOP, 1'b1);
    complete();
    // out-of-range write must not alias onto word 0
    write_word(32'h1000, 32'hDEAD_BEEF);
    issue(32'h0, 32'h0050_0093, 1'b0);
    complete();
    issue(32'hFFFF_FFFC, NOP, 1'b1);
    complete();
  endtask

  task automatic test_backpressure;
    logic [31:0] a_instr;
    issue(32'h4, 32'h00A0_0113, 1'b0);
    a_instr = rsp_instr;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 32'h0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00A0_0113 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc%0d: got valid=%b instr=%h err=%b ready=%b expected 1/%h/0/0",
                 i, rsp_valid, rsp_instr, rsp_err, req_ready, a_instr);
      end
    end
    req_valid = 1'b0;
    complete();
  endtask

  // write_edge: which edge after the accept edge (1 or 2) samples the write
  task automatic test_collision(input int write_edge, input logic [31:0] ei);
    exp_t e;
    write_word(32'h8, 32'hAAAA_AAAA);
    e.instr = ei; e.err = 1'b0;
    sb.push_back(e);
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      wr_en = (k == write_edge); wr_addr = 32'h8; wr_data = 32'h5555_5555;
      tick();
    end
    wr_en = 1'b0;
    checks++;
    e = sb.pop_front();
    if (rsp_valid !== 1'b1 || rsp_instr !== e.instr || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL collision edge%0d: got valid=%b instr=%h err=%b expected 1/%h/0",
               write_edge, rsp_valid, rsp_instr, rsp_err, e.instr);
    end
    complete();
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got valid=%b instr=%h err=%b ready=%b expected 0/0/0/0",
               rsp_valid, rsp_instr, rsp_err, req_ready);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL stray_response cyc%0d: got valid=%b ready=%b expected 0/1", i, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_wait0;
    logic [31:0] addrs [4];
    exp_t e;
    int idx;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h6; addrs[3] = 32'h4;
    z_write_word(32'h0, 32'h0050_0093);
    z_write_word(32'h4, 32'h00A0_0113);
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1; z_req_addr = 32'h0;
    tick();
    z_req_valid = 1'b0;
    checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_instr !== 32'h0050_0093 || z_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wait0_single: got valid=%b instr=%h err=%b expected 1/00500093/0",
               z_rsp_valid, z_rsp_instr, z_rsp_err);
    end
    tick();
    checks++;
    if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait0_done: got valid=%b ready=%b expected 0/1", z_rsp_valid, z_req_ready);
    end
    // back-to-back: one response every other edge
    idx = 0;
    z_req_valid = 1'b1; z_req_addr = addrs[0];
    e.instr = 32'h0050_0093; e.err = 1'b0; sb.push_back(e);
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      checks++;
      if (z_rsp_valid !== ((cyc % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_valid cyc%0d: got %b expected %b", cyc, z_rsp_valid, (cyc % 2) == 0);
      end
      if (z_rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_scoreboard_empty cyc%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (z_rsp_instr !== e.instr || z_rsp_err !== e.err) begin
            errors++;
            $display("FAIL b2b_data cyc%0d: got instr=%h err=%b expected instr=%h err=%b",
                     cyc, z_rsp_instr, z_rsp_err, e.instr, e.err);
          end
        end
      end
      if (z_req_ready === 1'b1) begin
        idx++;
        if (idx < 4) begin
          z_req_addr = addrs[idx];
          case (idx)
            1, 3:    begin e.instr = 32'h00A0_0113; e.err = 1'b0; end
            default: begin e.instr = NOP; e.err = 1'b1; end
          endcase
          sb.push_back(e);
        end else begin
          z_req_valid = 1'b0;
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_leftover: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    z_req_valid = 1'b0; z_req_addr = '0; z_rsp_ready = 1'b0;
    z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    tick();
    tick();
    test_reset();
    tick();
    test_fetch();
    test_errors();
    test_backpressure();
    test_collision(2, 32'hAAAA_AAAA);
    test_collision(1, 32'h5555_5555);
    test_reset_mid_wait();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
